// File: rtl/line_clear_controller.sv
// line_clear_controller: scans the board bottom-up, compacts surviving rows and zero-fills the top (optional LINE_CLEAR_SCORE_EN adds a score output)
module line_clear_controller #(
   parameter int ROWS = 20,
   parameter int COLS = 10,
   parameter int AW   = 5,
   parameter int CW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [CW-1:0]   lines_cleared,
`ifdef LINE_CLEAR_SCORE_EN
   output logic [15:0]     score,
`endif
   output logic [AW-1:0]   mem_addr,
   output logic            mem_rd_en,
   input  logic [COLS-1:0] mem_rdata,
   output logic            mem_wr_en,
   output logic [COLS-1:0] mem_wdata
);
   typedef enum logic [2:0] {S_IDLE, S_RD, S_EVAL, S_WR, S_CLR, S_DONE} state_t;
   state_t          r_state, w_state;
   logic [AW-1:0]   r_rd_ptr, w_rd_ptr, r_wr_ptr, w_wr_ptr;
   logic [CW-1:0]   r_cnt, w_cnt, r_fill, w_fill, w_lines;
   logic [COLS-1:0] r_row_buf, w_row_buf;
   logic            w_full, w_last, w_move;
   // state and datapath registers; reset abandons any pass in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_cnt         <= '0;
         r_fill        <= '0;
         r_row_buf     <= '0;
         lines_cleared <= '0;
      end else begin
         r_state       <= w_state;
         r_rd_ptr      <= w_rd_ptr;
         r_wr_ptr      <= w_wr_ptr;
         r_cnt         <= w_cnt;
         r_fill        <= w_fill;
         r_row_buf     <= w_row_buf;
         lines_cleared <= w_lines;
      end
   end
   // next-state, RAM strobes and datapath updates; read and write strobes come from disjoint states
   always_comb begin
      w_state   = r_state;
      w_rd_ptr  = r_rd_ptr;
      w_wr_ptr  = r_wr_ptr;
      w_cnt     = r_cnt;
      w_fill    = r_fill;
      w_row_buf = r_row_buf;
      w_lines   = lines_cleared;
      busy      = r_state != S_IDLE;
      done      = 1'b0;
      mem_addr  = '0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_wdata = '0;
      w_full    = &mem_rdata;
      w_last    = r_rd_ptr == '0;
      w_move    = !w_full && r_wr_ptr != r_rd_ptr;
      case (r_state)
         S_IDLE: if (start) begin
            w_rd_ptr = AW'(ROWS - 1);
            w_wr_ptr = AW'(ROWS - 1);
            w_cnt    = '0;
            w_lines  = '0;
            w_state  = S_RD;
         end
         S_RD: begin
            mem_rd_en = 1'b1;
            mem_addr  = r_rd_ptr;
            w_state   = S_EVAL;
         end
         S_EVAL: begin
            w_cnt = w_full ? r_cnt + 1'b1 : r_cnt;
            if (!w_full && r_wr_ptr == r_rd_ptr) w_wr_ptr = r_wr_ptr - 1'b1;
            if (w_move) begin
               w_row_buf = mem_rdata;
               w_state   = S_WR;
            end else if (w_last) begin
               w_fill  = w_cnt;
               w_state = (w_cnt != '0) ? S_CLR : S_DONE;
            end else begin
               w_rd_ptr = r_rd_ptr - 1'b1;
               w_state  = S_RD;
            end
         end
         S_WR: begin
            mem_wr_en = 1'b1;
            mem_addr  = r_wr_ptr;
            mem_wdata = r_row_buf;
            w_wr_ptr  = r_wr_ptr - 1'b1;
            if (w_last) begin
               w_fill  = r_cnt;
               w_state = (r_cnt != '0) ? S_CLR : S_DONE;
            end else begin
               w_rd_ptr = r_rd_ptr - 1'b1;
               w_state  = S_RD;
            end
         end
         S_CLR: begin
            mem_wr_en = 1'b1;
            mem_addr  = r_wr_ptr;
            w_wr_ptr  = r_wr_ptr - 1'b1;
            w_fill    = r_fill - 1'b1;
            if (r_fill == CW'(1)) w_state = S_DONE;
         end
         S_DONE: begin
            done    = 1'b1;
            w_lines = r_cnt;
            w_state = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase
   end
`ifdef LINE_CLEAR_SCORE_EN
   logic [3:0]  w_pts;
   logic [16:0] w_sum;
   // points for this pass and the unsaturated running total
   always_comb begin
      w_pts = (r_cnt == '0) ? 4'd0 : (r_cnt == CW'(1)) ? 4'd1 : (r_cnt == CW'(2)) ? 4'd3 :
              (r_cnt == CW'(3)) ? 4'd5 : 4'd8;
      w_sum = {1'b0, score} + 17'(w_pts);
   end
   // score accumulates once per finished pass and sticks at all-ones
   always_ff @(posedge clk) begin
      if (rst) score <= '0;
      else if (r_state == S_DONE) score <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
   end
`endif
endmodule
